fft_addr_gen: RTL and testbench

Butterfly address/twiddle sequencer for the in-place radix-2 DIT 256-point FFT core. For each stage it issues 128 butterfly operand-address pairs (addr_a, addr_b) plus a twiddle index to the butterfly datapath over a valid/ready handshake. After the last butterfly of a stage it pulses stage_strobe into the downstream stage counter, then reads back that counter's stage count and stage_done flag to decide whether to run the next stage or finish.

---
 rtl/fft_addr_gen.sv | 131 +++++++++++++
 tb/tb_fft_addr_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// Butterfly address and twiddle sequencer for an in-place radix-2 DIT FFT.
// Optional macro ADDR_GEN_ABORT_EN adds an abort input that returns the sequencer to IDLE.
`timescale 1ns/1ps
module fft_addr_gen #(
  parameter int N_LOG2 = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        stage_in,
  input  logic              stage_done_in,
  input  logic              bf_ready,
`ifdef ADDR_GEN_ABORT_EN
  input  logic              abort,
`endif
  output logic              bf_valid,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              stage_strobe,
  output logic              busy,
  output logic              fft_done
);

  localparam int KW = N_LOG2 - 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0]        STAGES = 4'(N_LOG2);
  localparam logic [3:0]        TW_TOP = 4'(N_LOG2 - 1);
  localparam logic [KW-1:0]     K_LAST = '1;
  localparam logic [KW-1:0]     K_ONE  = KW'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic              busy_q, busy_d;

  logic              run_ok;
  logic              xfer;
  logic [ADDR_W-1:0] k_ext, half, mask, a_raw, b_raw;
  logic [3:0]        tw_sh;
  logic [KW-1:0]     tw_raw;

  // Operand pair: split k into group (upper bits) and position inside the group.
  always_comb begin
    k_ext  = ADDR_W'(k_q);
    half   = A_ONE << stage_in;
    mask   = half - A_ONE;
    a_raw  = ((k_ext >> stage_in) << (stage_in + 4'd1)) | (k_ext & mask);
    b_raw  = a_raw + half;
    tw_sh  = TW_TOP - stage_in;
    tw_raw = (k_q & KW'(mask)) << tw_sh;
  end

  // An out-of-range stage never presents a butterfly, so RUN simply waits.
  assign run_ok       = (state_q == S_RUN) && (stage_in < STAGES);
  assign xfer         = run_ok && bf_ready;
  assign bf_valid     = run_ok;
  assign addr_a       = run_ok ? a_raw  : '0;
  assign addr_b       = run_ok ? b_raw  : '0;
  assign tw_idx       = run_ok ? tw_raw : '0;
  assign stage_strobe = (state_q == S_STROBE);
  assign fft_done     = (state_q == S_DONE);
  assign busy         = busy_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) begin
            state_d = S_STROBE;
          end
        end
      end
      S_STROBE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (stage_done_in || (stage_in >= STAGES)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
`ifdef ADDR_GEN_ABORT_EN
    // Abort outranks a transfer in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      k_d     = '0;
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: vector table for addressing, plus handshake,
// full-transform and reset/abort sequences against a behavioural stage counter.
`timescale 1ns/1ps
module tb_fft_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stage_done_in, bf_ready;
  logic [3:0] stage_in;
  logic       bf_valid, stage_strobe, busy, fft_done;
  logic [7:0] addr_a, addr_b;
  logic [6:0] tw_idx;
`ifdef ADDR_GEN_ABORT_EN
  logic       abort;
`endif

  logic       use_cnt, man_done, cnt_done;
  logic [3:0] man_stage, cnt_stage;

  assign stage_in      = use_cnt ? cnt_stage : man_stage;
  assign stage_done_in = use_cnt ? cnt_done  : man_done;

  fft_addr_gen #(.N_LOG2(8), .ADDR_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stage_in(stage_in),
    .stage_done_in(stage_done_in),
    .bf_ready(bf_ready),
`ifdef ADDR_GEN_ABORT_EN
    .abort(abort),
`endif
    .bf_valid(bf_valid),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .tw_idx(tw_idx),
    .stage_strobe(stage_strobe),
    .busy(busy),
    .fft_done(fft_done)
  );

  // Downstream stage counter: counts strobes, rolls over after stage 7 and flags done.
  always @(posedge clk) begin
    if (reset) begin
      cnt_stage <= 4'd0;
      cnt_done  <= 1'b0;
    end else if (stage_strobe) begin
      if (cnt_stage == 4'd7) begin
        cnt_stage <= 4'd0;
        cnt_done  <= 1'b1;
      end else begin
        cnt_stage <= cnt_stage + 4'd1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    start    = 1'b0;
    bf_ready = 1'b0;
`ifdef ADDR_GEN_ABORT_EN
    abort    = 1'b0;
`endif
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic run_to_k(input int s, input int k);
    man_stage = 4'(s);
    start = 1'b1;
    tick;
    start = 1'b0;
    bf_ready = 1'b1;
    repeat (k) tick;
    bf_ready = 1'b0;
  endtask

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, xf, early, seen, stall_bad, last_a, last_b, last_tw;
    int prev_v, prev_r, prev_a, prev_b, prev_tw, g, p;
    int strobes, dones, done_cyc, busy_after;

    vecs[0]  = '{2,   5,   9,  13, 32};
    vecs[1]  = '{7,   5,   5, 133,  5};
    vecs[2]  = '{0,   0,   0,   1,  0};
    vecs[3]  = '{0,   1,   2,   3,  0};
    vecs[4]  = '{0, 127, 254, 255,  0};
    vecs[5]  = '{1,   3,   5,   7, 64};
    vecs[6]  = '{3,  37,  69,  77, 80};
    vecs[7]  = '{6, 100, 164, 228, 72};
    vecs[8]  = '{4,  10,  10,  26, 80};
    vecs[9]  = '{5,  77, 141, 173, 52};
    vecs[10] = '{7, 127, 127, 255, 127};

    use_cnt   = 1'b0;
    man_stage = 4'd0;
    man_done  = 1'b0;
    do_reset;

    chk("rst_valid",  int'(bf_valid), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_strobe", int'(stage_strobe), 0);
    chk("rst_done",   int'(fft_done), 0);
    chk("rst_addr_a", int'(addr_a), 0);
    chk("rst_addr_b", int'(addr_b), 0);
    chk("rst_tw",     int'(tw_idx), 0);

    for (int i = 0; i < 11; i++) begin
      do_reset;
      run_to_k(vecs[i].s, vecs[i].k);
      $display("vec%0d s=%0d k=%0d a=%0d b=%0d tw=%0d", i, vecs[i].s, vecs[i].k,
               addr_a, addr_b, tw_idx);
      chk($sformatf("vec%0d_valid", i), int'(bf_valid), 1);
      chk($sformatf("vec%0d_a", i), int'(addr_a), vecs[i].a);
      chk($sformatf("vec%0d_b", i), int'(addr_b), vecs[i].b);
      chk($sformatf("vec%0d_tw", i), int'(tw_idx), vecs[i].tw);
      tick;
      chk($sformatf("vec%0d_hold_a", i), int'(addr_a), vecs[i].a);
    end

    // Reset in the middle of a stage
    do_reset;
    run_to_k(3, 37);
    chk("midrun_pre_a", int'(addr_a), 69);
    bf_ready = 1'b1;
    reset = 1'b1;
    tick;
    chk("midrun_busy", int'(busy), 0);
    chk("midrun_valid", int'(bf_valid), 0);
    chk("midrun_strobe", int'(stage_strobe), 0);
    reset = 1'b0;
    tick;
    chk("midrun_stay_idle", int'(busy), 0);

    // Stage 0 sweep with ready held high
    do_reset;
    man_stage = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    bf_ready = 1'b1;
    bad = 0; xf = 0; early = 0; last_a = -1; last_b = -1; last_tw = -1;
    for (int c = 0; c < 200 && xf < 128; c++) begin
      if (stage_strobe) early++;
      if (bf_valid) begin
        if (int'(addr_a) != 2 * xf || int'(addr_b) != 2 * xf + 1 || tw_idx != 7'd0) bad++;
        last_a = int'(addr_a); last_b = int'(addr_b); last_tw = int'(tw_idx);
        xf++;
      end
      tick;
    end
    $display("stage0 sweep: transfers=%0d last=(%0d,%0d,%0d)", xf, last_a, last_b, last_tw);
    chk("s0_transfers", xf, 128);
    chk("s0_bad_ops", bad, 0);
    chk("s0_early_strobe", early, 0);
    chk("s0_last_a", last_a, 254);
    chk("s0_last_b", last_b, 255);
    chk("s0_last_tw", last_tw, 0);
    chk("s0_strobe", int'(stage_strobe), 1);
    chk("s0_strobe_valid", int'(bf_valid), 0);
    tick;
    chk("s0_check_strobe", int'(stage_strobe), 0);
    chk("s0_check_valid", int'(bf_valid), 0);
    tick;
    chk("s0_rerun_valid", int'(bf_valid), 1);
    chk("s0_rerun_a", int'(addr_a), 0);

    // Stage 3 with pseudo-random ready
    do_reset;
    man_stage = 4'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    prev_v = 0; prev_r = 0; prev_a = 0; prev_b = 0; prev_tw = 0;
    xf = 0; bad = 0; stall_bad = 0; seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_v == 1 && prev_r == 1) begin
        g = xf / 8;
        p = xf % 8;
        if (prev_a != g * 16 + p || prev_b != g * 16 + p + 8 || prev_tw != p * 16) bad++;
        xf++;
      end else if (prev_v == 1 && prev_r == 0) begin
        if (!bf_valid || int'(addr_a) != prev_a || int'(addr_b) != prev_b ||
            int'(tw_idx) != prev_tw) stall_bad++;
      end
      if (stage_strobe) begin
        seen = 1;
        break;
      end
      prev_v  = int'(bf_valid);
      prev_a  = int'(addr_a);
      prev_b  = int'(addr_b);
      prev_tw = int'(tw_idx);
      prev_r  = int'($urandom_range(0, 1));
      bf_ready = prev_r[0];
      tick;
    end
    bf_ready = 1'b0;
    $display("stage3 random ready: transfers=%0d seq_bad=%0d stall_bad=%0d", xf, bad, stall_bad);
    chk("rnd_strobe_seen", seen, 1);
    chk("rnd_transfers", xf, 128);
    chk("rnd_seq_bad", bad, 0);
    chk("rnd_stall_bad", stall_bad, 0);

    // Out-of-range stage never raises bf_valid
    do_reset;
    man_stage = 4'd8;
    start = 1'b1;
    tick;
    start = 1'b0;
    bf_ready = 1'b1;
    tick;
    tick;
    chk("oor_valid", int'(bf_valid), 0);
    chk("oor_busy", int'(busy), 1);
    chk("oor_strobe", int'(stage_strobe), 0);

    // Full transform driven by the stage counter
    do_reset;
    use_cnt = 1'b1;
    bf_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    strobes = 0; dones = 0; done_cyc = -1; busy_after = -1;
    for (int c = 1; c <= 1100; c++) begin
      if (stage_strobe) strobes++;
      if (done_cyc > 0 && c == done_cyc + 1) busy_after = int'(busy);
      if (fft_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    start = 1'b0;
    $display("full transform: strobes=%0d dones=%0d done_cycle=%0d", strobes, dones, done_cyc);
    chk("full_strobes", strobes, 8);
    chk("full_dones", dones, 1);
    chk("full_done_cycle", done_cyc, 1041);
    chk("full_busy_after_done", busy_after, 0);
    chk("full_start_in_done_ignored", int'(busy), 0);
    use_cnt = 1'b0;

`ifdef ADDR_GEN_ABORT_EN
    do_reset;
    run_to_k(4, 10);
    chk("abort_pre_a", int'(addr_a), 10);
    bf_ready = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    bf_ready = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(bf_valid), 0);
    strobes = 0; dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (stage_strobe) strobes++;
      if (fft_done) dones++;
      tick;
    end
    chk("abort_no_strobe", strobes, 0);
    chk("abort_no_done", dones, 0);
    run_to_k(4, 0);
    $display("abort restart: a=%0d b=%0d", addr_a, addr_b);
    chk("abort_restart_a", int'(addr_a), 0);
    chk("abort_restart_b", int'(addr_b), 16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
